dmem_arbiter: RTL
=================

# dmem_arbiter

Single-cycle arbiter that shares the data-memory port between the pipeline MEM stage (requester `cpu`) and the debug/loader bus (requester `dbg`). It sits between the EX/MEM register and a data memory with one-cycle registered read latency. It issues exactly one memory access per cycle and returns read data to the owner one cycle later. It also produces the `stall` signal the hazard unit uses to freeze PC, IF/ID, ID/EX and EX/MEM.

## Interface
Parameters:
- `AW`, 10: word-address width into data memory.
- `DW`, 32: data width.
- `STARVE_MAX`, 15: debug wait-cycle limit before forced debug grant; range 1..255.

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous active-high reset
- `cpu_req`  in  1  MEM-stage access request
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  AW  word address
- `cpu_wdata`  in  DW  write data
- `cpu_gnt`  out  1  access issued this cycle
- `cpu_rvalid`  out  1  read data valid
- `cpu_rdata`  out  DW  read data
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: same widths and meanings, for the debug requester
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, valid the cycle after a read `mem_en`
- `stall`  out  1  freeze pipeline this cycle

## Operation
- Arbitration is evaluated every cycle.
  - Default priority: cpu over dbg.
  - If `starve` is set (see Configuration), dbg wins instead.
- Grant is one-hot or zero. `mem_en` = `cpu_gnt | dbg_gnt`.
  - `mem_we`, `mem_addr` and `mem_wdata` are muxed from the winner.
  - All four are 0 when there is no grant.
- Read tracking registers:
  - `rd_pend` is set next cycle iff the granted access was a read.
  - `rd_owner` records the owner: 0 = cpu, 1 = dbg.
- Read return:
  - `cpu_rvalid` = `rd_pend & ~rd_owner`; `dbg_rvalid` = `rd_pend & rd_owner`.
  - Both `*_rdata` = `mem_rdata` and are qualified only by their `rvalid`.
- A new access may be granted in the same cycle that a previous read returns (back-to-back reads, one per cycle).
- `stall` = `(cpu_req & ~cpu_gnt) | (cpu_gnt & ~cpu_we)`.
  - A cpu read stalls its grant cycle and completes the next cycle, when `cpu_rvalid` = 1.
  - A cpu write completes in one cycle with no stall.
- Requesters must hold `req` and its payload stable until they see `gnt`.
- Dropping `req` before grant is legal; nothing is issued.

## Timing
- Grant, `mem_*` outputs and `stall` are combinational from the requests and registered state.
- Read latency is 1 cycle from grant to `rvalid`. Write latency is 0; memory updates on the grant-cycle edge.
- Reset values: `rd_pend` = 0, `rd_owner` = 0, `wait_cnt` = 0, `starve` = 0.
  - All `rvalid` outputs are 0 during and after reset.
  - With no requests, all grant, `mem_*` and `stall` outputs are 0.
- Reset asserted while a read is pending: the read is discarded and no `rvalid` follows.
- Simultaneous cpu and dbg requests: exactly one is granted and the loser is re-evaluated next cycle.

## Configuration
- `DMEM_ARB_STARVE_EN` defined: starvation guard is compiled in.
  - 8-bit `wait_cnt` increments each cycle `dbg_req & ~dbg_gnt`, saturating at `STARVE_MAX`.
  - `wait_cnt` clears on `dbg_gnt` or on `~dbg_req`.
  - `starve` = (`wait_cnt` == `STARVE_MAX`), which gives dbg priority for one grant.
- `DMEM_ARB_STARVE_EN` undefined:
  - No counter is built and `starve` is tied to 0.
  - Priority is strictly cpu first; dbg may starve indefinitely.

## Structure
- Shared package `dmem_pkg` holds:
  - `OWNER_CPU` = 1'b0 and `OWNER_DBG` = 1'b1;
  - default `AW`/`DW`;
  - the requester bundle typedef (req, we, addr, wdata).
- No sub-module is needed. The starvation counter stays inline, guarded by the macro.

## Test plan
- cpu read of addr 0x010 (mem holds 0xDEADBEEF), dbg idle -> cycle 0: `cpu_gnt` = 1, `stall` = 1; cycle 1: `cpu_rvalid` = 1, `cpu_rdata` = 0xDEADBEEF, `stall` = 0.
- cpu write 0x12345678 to 0x020 and dbg read 0x020 requested in the same cycle -> cpu granted, `stall` = 0; dbg granted next cycle; `dbg_rdata` = 0x12345678 one cycle after that.
- Back-to-back dbg reads of 0x000, 0x001, 0x002 -> `dbg_gnt` high 3 consecutive cycles, `dbg_rvalid` high 3 consecutive cycles starting one cycle later, data in order.
- Macro on, `STARVE_MAX` = 4, cpu_req and dbg_req held high -> cpu granted cycles 0..3; dbg granted cycle 4 with `stall` = 1; cpu granted cycle 5; pattern repeats. Macro off -> dbg never granted.
- cpu read granted, `rst` asserted the next cycle -> no `cpu_rvalid`; after reset all `rvalid` = 0 and `wait_cnt` = 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter: owner encoding,
// default widths and the requester bundle.
package dmem_pkg;

  localparam int DMEM_AW = 10;
  localparam int DMEM_DW = 32;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;

  typedef struct packed {
    logic               req;
    logic               we;
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the MEM stage (cpu) and the debug/loader bus (dbg).
// Optional dbg starvation guard compiled in when DMEM_ARB_STARVE_EN is defined.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW         = DMEM_AW,
  parameter int DW         = DMEM_DW,
  parameter int STARVE_MAX = 15
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,

  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          stall
);

  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
    $error("dmem_arbiter: STARVE_MAX must be within 1..255");
  end

  logic rd_pend_q, rd_pend_d;
  logic rd_owner_q, rd_owner_d;
  logic starve;
  logic dbg_win;

  always_comb begin
    dbg_win   = dbg_req & (starve | ~cpu_req);
    cpu_gnt   = cpu_req & ~dbg_win;
    dbg_gnt   = dbg_win;
    mem_en    = cpu_gnt | dbg_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end

    // A cpu read holds the pipeline for its grant cycle; writes retire immediately.
    stall = (cpu_req & ~cpu_gnt) | (cpu_gnt & ~cpu_we);

    rd_pend_d  = mem_en & ~mem_we;
    rd_owner_d = rd_owner_q;
    if (mem_en) begin
      rd_owner_d = dbg_gnt ? OWNER_DBG : OWNER_CPU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWNER_CPU;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Gating with rst drops a read that was in flight when reset arrived.
  assign cpu_rvalid = rd_pend_q & (rd_owner_q == OWNER_CPU) & ~rst;
  assign dbg_rvalid = rd_pend_q & (rd_owner_q == OWNER_DBG) & ~rst;
  assign cpu_rdata  = mem_rdata;
  assign dbg_rdata  = mem_rdata;

`ifdef DMEM_ARB_STARVE_EN
  localparam logic [7:0] STARVE_LIMIT = 8'(STARVE_MAX);

  logic [7:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (dbg_gnt || !dbg_req) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != STARVE_LIMIT) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign starve = (wait_cnt_q == STARVE_LIMIT);
`else
  assign starve = 1'b0;
`endif

endmodule
